// File: rtl/dac_code_sequencer.sv
// Code source for the thermometer DAC encoder: host stream FIFO, bounded triangle generator or static hold level.
// Optional macro DAC_SEQ_PARK_EN: drive code_out to zero with one strobe whenever the sequencer falls back to IDLE.

module dac_code_sequencer #(
    parameter int CODE_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic [1:0]               cfg_mode,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic [CODE_W-1:0]        cfg_lo,
    input  logic [CODE_W-1:0]        cfg_hi,
    input  logic                     s_valid,
    input  logic [CODE_W-1:0]        s_data,
    output logic                     s_ready,
    output logic [CODE_W-1:0]        code_out,
    output logic                     code_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        TRI_UP,
        TRI_DN,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [1:0]          mode_q;
    logic [DIV_W-1:0]    div_q;
    logic [CODE_W-1:0]   lo_q;
    logic [CODE_W-1:0]   hi_q;
    logic [DIV_W-1:0]    presc;

    logic [CODE_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;

    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_nxt;
    logic                strobe_q;
    logic                strobe_nxt;
    logic                underrun_q;
    logic                underrun_nxt;

    logic                tick;
    logic                push;
    logic                pop;
    logic [CODE_W-1:0]   code_inc;
    logic [CODE_W-1:0]   code_dec;

    // Ticks only count while engaged; the cycle in which cfg_en drops performs no update.
    assign tick     = (state != IDLE) && cfg_en && (presc == div_q);
    assign push     = s_valid && (level != FULL_LVL);
    assign code_inc = code_q + 1'b1;
    assign code_dec = code_q - 1'b1;

    // Configuration follows the inputs while disabled and freezes once enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= '0;
            div_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else if (!cfg_en) begin
            mode_q <= cfg_mode;
            div_q  <= cfg_div;
            lo_q   <= cfg_lo;
            hi_q   <= cfg_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE)) begin
            presc <= '0;
        end else if (presc == div_q) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_en) begin
                    case (mode_q)
                        2'd0:    state_nxt = STREAM;
                        2'd1:    state_nxt = (hi_q > lo_q) ? TRI_UP : HOLD;
                        default: state_nxt = HOLD;
                    endcase
                end
            end
            TRI_UP:  if (tick && (code_inc == hi_q)) state_nxt = TRI_DN;
            TRI_DN:  if (tick && (code_dec == lo_q)) state_nxt = TRI_UP;
            default: state_nxt = state;
        endcase
        if ((state != IDLE) && !cfg_en) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        code_nxt     = code_q;
        strobe_nxt   = 1'b0;
        underrun_nxt = underrun_q;
        pop          = 1'b0;
        if (state == IDLE) begin
            if (cfg_en) begin
                underrun_nxt = 1'b0;
                if (state_nxt != STREAM) begin
                    code_nxt   = lo_q;
                    strobe_nxt = 1'b1;
                end
            end
        end else if (!cfg_en) begin
`ifdef DAC_SEQ_PARK_EN
            code_nxt   = '0;
            strobe_nxt = 1'b1;
`else
            code_nxt   = code_q;
`endif
        end else if (tick) begin
            case (state)
                STREAM: begin
                    if (level != '0) begin
                        pop        = 1'b1;
                        code_nxt   = mem[rd_ptr];
                        strobe_nxt = 1'b1;
                    end else begin
                        underrun_nxt = 1'b1;
                    end
                end
                TRI_UP: begin
                    code_nxt   = code_inc;
                    strobe_nxt = 1'b1;
                end
                TRI_DN: begin
                    code_nxt   = code_dec;
                    strobe_nxt = 1'b1;
                end
                default: code_nxt = code_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q     <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            code_q     <= code_nxt;
            strobe_q   <= strobe_nxt;
            underrun_q <= underrun_nxt;
        end
    end

    // Registered-read FIFO: a byte written this cycle is only visible to the pop logic next cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign s_ready     = (level != FULL_LVL);
    assign code_out    = code_q;
    assign code_strobe = strobe_q;
    assign fifo_level  = level;
    assign underrun    = underrun_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dac_code_sequencer.sv
// Self-checking bench for dac_code_sequencer: directed scenarios plus random traffic against a queue-based model.
// Build with DAC_SEQ_PARK_EN defined to check the parking variant.

module tb_dac_code_sequencer;

    localparam int DEPTH = 8;
    localparam int K_STREAM = 0;
    localparam int K_TRI    = 1;
    localparam int K_HOLD   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_en;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_div;
    logic [7:0] cfg_lo;
    logic [7:0] cfg_hi;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] code_out;
    logic       code_strobe;
    logic [3:0] fifo_level;
    logic       underrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Reference model: a byte queue plus a few abstract flags.
    int q[$];
    bit m_active;
    int m_kind;
    bit m_rising;
    int m_count;
    int m_code;
    bit m_strobe;
    bit m_under;
    int lat_mode, lat_div, lat_lo, lat_hi;

    bit collect;
    int seen[$];

    dac_code_sequencer #(.CODE_W(8), .DEPTH(DEPTH), .DIV_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .cfg_mode    (cfg_mode),
        .cfg_div     (cfg_div),
        .cfg_lo      (cfg_lo),
        .cfg_hi      (cfg_hi),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .code_out    (code_out),
        .code_strobe (code_strobe),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        bit can_push;
        if (!rst_n) begin
            q.delete();
            m_active = 0; m_kind = K_STREAM; m_rising = 0; m_count = 0;
            m_code = 0; m_strobe = 0; m_under = 0;
            lat_mode = 0; lat_div = 0; lat_lo = 0; lat_hi = 0;
            return;
        end
        can_push = (q.size() < DEPTH);
        m_strobe = 0;
        if (!m_active) begin
            if (cfg_en) begin
                m_active = 1;
                m_under  = 0;
                m_count  = 0;
                if (lat_mode == 0) begin
                    m_kind = K_STREAM;
                end else begin
                    m_code   = lat_lo;
                    m_strobe = 1;
                    if (lat_mode == 1 && lat_hi > lat_lo) begin
                        m_kind   = K_TRI;
                        m_rising = 1;
                    end else begin
                        m_kind = K_HOLD;
                    end
                end
            end
        end else if (!cfg_en) begin
            m_active = 0;
            m_count  = 0;
`ifdef DAC_SEQ_PARK_EN
            m_code   = 0;
            m_strobe = 1;
`endif
        end else if (m_count == lat_div) begin
            m_count = 0;
            if (m_kind == K_STREAM) begin
                if (q.size() > 0) begin
                    m_code   = q.pop_front();
                    m_strobe = 1;
                end else begin
                    m_under = 1;
                end
            end else if (m_kind == K_TRI) begin
                m_code   = m_rising ? m_code + 1 : m_code - 1;
                m_strobe = 1;
                if (m_code == lat_hi) m_rising = 0;
                if (m_code == lat_lo) m_rising = 1;
            end
        end else begin
            m_count++;
        end
        if (!cfg_en) begin
            lat_mode = cfg_mode; lat_div = cfg_div; lat_lo = cfg_lo; lat_hi = cfg_hi;
        end
        if (s_valid && can_push) q.push_back(int'(s_data));
    endtask

    task automatic compareAll();
        checkOutput("code_out",    int'(code_out),    m_code);
        checkOutput("code_strobe", int'(code_strobe), int'(m_strobe));
        checkOutput("fifo_level",  int'(fifo_level),  q.size());
        checkOutput("s_ready",     int'(s_ready),     int'(q.size() < DEPTH));
        checkOutput("underrun",    int'(underrun),    int'(m_under));
        checkOutput("busy",        int'(busy),        int'(m_active));
    endtask

    task automatic applyStimulus(input bit v, input int d);
        s_valid = v;
        s_data  = 8'(d);
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        if (collect && code_strobe) seen.push_back(int'(code_out));
        @(negedge clk);
    endtask

    initial begin
        int hold_strobes;
        int fill[$];
        bit reached;
        int lo_i, hi_i;

        rst_n = 0; cfg_en = 0; cfg_mode = 0; cfg_div = 0; cfg_lo = 0; cfg_hi = 0;
        s_valid = 0; s_data = 0; collect = 0;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        rst_n = 1;
        applyStimulus(0, 0);
        checkOutput("reset_level", int'(fifo_level), 0);

        // Stream with div=3: three codes then an underrun.
        cfg_mode = 2'd0; cfg_div = 8'd3;
        applyStimulus(1, 'h10);
        applyStimulus(1, 'h20);
        applyStimulus(1, 'h30);
        cfg_en = 1; collect = 1; seen.delete();
        repeat (18) applyStimulus(0, 0);
        collect = 0;
        checkOutput("stream_count", seen.size(), 3);
        if (seen.size() == 3) begin
            checkOutput("stream_c0", seen[0], 'h10);
            checkOutput("stream_c1", seen[1], 'h20);
            checkOutput("stream_c2", seen[2], 'h30);
        end
        checkOutput("stream_underrun", int'(underrun), 1);
        checkOutput("stream_hold", int'(code_out), 'h30);
        cfg_en = 0;
        applyStimulus(0, 0);

        // Triangle 2..5 at full rate, dropped when the output reaches 4 on the way down or up.
        cfg_mode = 2'd1; cfg_lo = 8'd2; cfg_hi = 8'd5; cfg_div = 8'd0;
        applyStimulus(0, 0);
        cfg_en = 1;
        repeat (10) applyStimulus(0, 0);
        reached = 0;
        for (int i = 0; i < 12 && !reached; i++) begin
            applyStimulus(0, 0);
            if (code_out == 8'd4) reached = 1;
        end
        checkOutput("tri_reach4", int'(reached), 1);
        cfg_en = 0;
        applyStimulus(0, 0);
`ifdef DAC_SEQ_PARK_EN
        checkOutput("drop_code", int'(code_out), 0);
`else
        checkOutput("drop_code", int'(code_out), 4);
`endif
        checkOutput("drop_busy", int'(busy), 0);

        // Degenerate triangle lo==hi behaves as hold.
        cfg_lo = 8'd7; cfg_hi = 8'd7;
        applyStimulus(0, 0);
        cfg_en = 1; hold_strobes = 0;
        for (int i = 0; i < 55; i++) begin
            applyStimulus(0, 0);
            if (code_strobe) hold_strobes++;
        end
        checkOutput("hold_strobes", hold_strobes, 1);
        checkOutput("hold_code", int'(code_out), 7);
        cfg_en = 0;
        applyStimulus(0, 0);

        // Fill beyond capacity, then drain and check order.
        cfg_mode = 2'd0; cfg_div = 8'd0;
        fill.delete();
        for (int i = 0; i < 8; i++) begin
            fill.push_back('h40 + i * 3);
            applyStimulus(1, 'h40 + i * 3);
        end
        checkOutput("full_ready", int'(s_ready), 0);
        checkOutput("full_level", int'(fifo_level), 8);
        applyStimulus(1, 'h99);
        checkOutput("full_level9", int'(fifo_level), 8);
        cfg_en = 1; collect = 1; seen.delete();
        repeat (12) applyStimulus(0, 0);
        collect = 0;
        checkOutput("drain_count", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) checkOutput("drain_order", seen[i], fill[i]);
        cfg_en = 0;
        applyStimulus(0, 0);

        // Simultaneous push and pop at level 1.
        applyStimulus(1, 'hA1);
        cfg_en = 1;
        applyStimulus(0, 0);
        applyStimulus(1, 'hB2);
        checkOutput("pp_level", int'(fifo_level), 1);
        checkOutput("pp_code", int'(code_out), 'hA1);
        applyStimulus(0, 0);
        checkOutput("pp_next", int'(code_out), 'hB2);
        cfg_en = 0;
        applyStimulus(0, 0);

        // Reset in the middle of STREAM with three queued bytes.
        cfg_div = 8'd7;
        applyStimulus(1, 1);
        applyStimulus(1, 2);
        applyStimulus(1, 3);
        cfg_en = 1;
        repeat (3) applyStimulus(0, 0);
        checkOutput("mid_busy", int'(busy), 1);
        rst_n = 0;
        applyStimulus(0, 0);
        rst_n = 1; cfg_en = 0;
        applyStimulus(0, 0);
        checkOutput("rst_level", int'(fifo_level), 0);
        checkOutput("rst_code", int'(code_out), 0);
        checkOutput("rst_underrun", int'(underrun), 0);

        // Random traffic with config noise while enabled.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) cfg_en = ~cfg_en;
            rst_n    = ($urandom_range(0, 599) != 0);
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_div  = 8'($urandom_range(0, 4));
            lo_i     = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) hi_i = int'($urandom_range(0, 255));
            else hi_i = lo_i + int'($urandom_range(0, 6));
            if (hi_i > 255) hi_i = 255;
            cfg_lo = 8'(lo_i);
            cfg_hi = 8'(hi_i);
            applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_code_sequencer.md
Name: dac_code_sequencer

Overview:
Sequences 8-bit codes into the thermometer-encoded current-steering DAC datapath at a programmable update rate. It has three sources: a host-fed byte stream buffered in a small FIFO, an internal bounded triangle generator, or a static hold level. Its code_out/code_strobe pair drives the encoder input, replacing the free-running triangle counter as the code source.

Parameters:
CODE_W, 8, code width (DAC input width)
DEPTH, 8, stream FIFO entries; must be a power of 2, at least 2
DIV_W, 8, update-rate divider width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_en  in  1  sequencer enable; mode, bounds and divider are sampled on its rising edge
cfg_mode  in  2  0=STREAM, 1=TRIANGLE, 2=HOLD, 3=reserved (treated as HOLD)
cfg_div  in  DIV_W  a tick occurs every cfg_div+1 cycles
cfg_lo  in  CODE_W  triangle lower bound / hold level
cfg_hi  in  CODE_W  triangle upper bound
s_valid  in  1  stream byte valid
s_data  in  CODE_W  stream byte
s_ready  out  1  FIFO can accept a byte (= !full)
code_out  out  CODE_W  registered code to the DAC encoder
code_strobe  out  1  one-cycle pulse in the same cycle code_out takes a new value
fifo_level  out  $clog2(DEPTH)+1  number of stored entries
underrun  out  1  sticky: a STREAM tick found the FIFO empty
busy  out  1  state != IDLE

Behaviour:
- Reset, and the cycle after reset releases: state IDLE, code_out=0, code_strobe=0, FIFO empty, fifo_level=0, s_ready=1, underrun=0, prescaler=0, busy=0. A reset mid-operation discards FIFO contents.
- Config latch: when cfg_en is low, the sequencer stays in IDLE and captures mode, lo, hi and div every cycle. Changes to cfg_* while enabled are ignored until cfg_en drops.
- Prescaler:
  - Cleared in IDLE; otherwise counts 0..div and wraps.
  - tick=1 when the count equals div, so div=0 gives a tick every cycle.
  - The first tick arrives div+1 cycles after leaving IDLE.
- FSM states: IDLE, STREAM, TRI_UP, TRI_DN, HOLD.
  - IDLE with cfg_en=1: next state is chosen from the latched mode. TRIANGLE with hi<=lo goes to HOLD.
  - Any state with cfg_en=0: IDLE on the next cycle. No drain; remaining FIFO entries are kept.
- Entry actions:
  - TRIANGLE and HOLD entry: code_out<=lo with code_strobe in the first non-IDLE cycle.
  - STREAM entry: no output change and no strobe.
  - Leaving IDLE clears underrun.
- STREAM, on each tick:
  - FIFO non-empty: pop the head to code_out and strobe.
  - FIFO empty: code_out holds, no strobe, underrun<=1.
- TRI_UP, on each tick: code_out<=code_out+1 with strobe. When code_out+1==hi, next state is TRI_DN.
- TRI_DN, on each tick: code_out<=code_out-1 with strobe. When code_out-1==lo, next state is TRI_UP.
- Triangle sequence: lo, lo+1, ..., hi, hi-1, ..., lo, lo+1, ... Each endpoint is emitted once per turn. hi=lo+1 alternates lo,hi.
- HOLD: no updates after entry.
- Latency: a tick in cycle t gives code_out/code_strobe valid in cycle t+1.
- FIFO:
  - Push when s_valid && s_ready, in any state including IDLE.
  - No fall-through: a byte pushed in cycle t is poppable from t+1. A push into an empty FIFO on a tick cycle still counts as an underrun.
  - Push and pop in the same cycle: fifo_level is unchanged.
  - Full: s_ready=0, and s_valid is ignored with no overwrite.
  - Pointers wrap modulo DEPTH.
- Arithmetic: triangle inc/dec never wraps, because the bounds are checked before the step.

Optional Feature:
Macro DAC_SEQ_PARK_EN.
- Defined: when leaving any non-IDLE state for IDLE, code_out<=0 with one code_strobe in that transition cycle. This parks the DAC at zero current.
- Not defined: code_out holds its last value in IDLE with no strobe.
- Reset behaviour is identical in both cases.

Test Plan:
- STREAM, div=3: push 0x10,0x20,0x30 with cfg_en low, then raise cfg_en → strobes every 4 cycles with codes 0x10,0x20,0x30; the 4th tick sets underrun=1 and code_out stays 0x30.
- TRIANGLE, lo=2, hi=5, div=0 → code_out per cycle 2,3,4,5,4,3,2,3,…; a strobe every cycle.
- TRIANGLE, lo=7, hi=7 → HOLD: a single strobe with code_out=7, then no further strobes over 50 cycles.
- FIFO full: push 9 bytes back-to-back, DEPTH=8 → s_ready low after the 8th, fifo_level=8; the 9th byte is not stored and the pop order is intact.
- cfg_en dropped mid-triangle at code 4, then rst_n asserted mid-STREAM with 3 entries → IDLE next cycle (code_out 4, or 0 with DAC_SEQ_PARK_EN); after reset fifo_level=0, code_out=0, underrun=0.
- Push and pop in the same cycle with level=1 → fifo_level stays 1 and the popped value is the older byte.
